// File: rtl/snp_rsp_pkg.sv
// Shared definitions for the snoop responder.
// MESI and snoop request/response codes mirror the cache_def encodings used
// across the cache subsystem; they are only re-exposed here for import.
package snp_rsp_pkg;

  // MESI line states
  localparam logic [2:0] MESI_I = 3'd0;
  localparam logic [2:0] MESI_S = 3'd1;
  localparam logic [2:0] MESI_E = 3'd2;
  localparam logic [2:0] MESI_M = 3'd3;

  // Snoop requests
  localparam logic [2:0] SNP_NO_REQ = 3'd0;
  localparam logic [2:0] SNP_RD     = 3'd1;
  localparam logic [2:0] SNP_RWITM  = 3'd2;
  localparam logic [2:0] SNP_INV    = 3'd3;

  // Snoop responses
  localparam logic [1:0] SNP_NO_RSP = 2'd0;
  localparam logic [1:0] SNP_FOUND  = 2'd1;
  localparam logic [1:0] SNP_FETCH  = 2'd2;

  // Result of decoding one snoop against the local line state
  typedef struct packed {
    logic [2:0] nxt_st;
    logic [1:0] rsp;
    logic       wb;
  } snp_dec_t;

  // A hit on an INVALID entry is treated as a miss
  function automatic logic line_present(input logic hit, input logic [2:0] st);
    return hit && (st != MESI_I);
  endfunction

  // Saturating 16-bit increment for the optional statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/snp_rsp_decode.sv
// Combinational snoop decode: given the request, whether the line is present
// and its current MESI state, produce the next state, the response and
// whether a writeback of the line is required.
module snp_rsp_decode
  import snp_rsp_pkg::*;
(
  input  logic [2:0] req,
  input  logic       present,
  input  logic [2:0] cur_st,
  output snp_dec_t   dec
);

  // Read snoops downgrade to SHARED, ownership/invalidate snoops to INVALID;
  // only a MODIFIED line carries data that must go back to memory.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    dec.nxt_st = cur_st;
    dec.rsp    = SNP_FETCH;
    dec.wb     = 1'b0;
    if (present) begin
      dec.rsp    = SNP_FOUND;
      dec.wb     = (cur_st == MESI_M);
      dec.nxt_st = (req == SNP_RD) ? MESI_S : MESI_I;
    end
  end

endmodule

// File: rtl/snp_rsp_ctrl.sv
// Snoop responder: accepts a snoop in IDLE, looks the line up in the local
// tag/state array, writes back MODIFIED data, then responds and updates the
// local MESI state.
// Optional feature: define SNP_RSP_STAT_EN to add saturating hit/miss/
// writeback counters (stat_hit, stat_miss, stat_wb).
module snp_rsp_ctrl
  import snp_rsp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        snp_req,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic [1:0]        snp_rsp,
  output logic              snp_busy,
  output logic              lk_req,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              lk_hit,
  input  logic [2:0]        lk_st,
  input  logic [DATA_W-1:0] lk_data,
  output logic              st_wr_en,
  output logic [ADDR_W-1:0] st_wr_addr,
  output logic [2:0]        st_wr_val,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready
`ifdef SNP_RSP_STAT_EN
  ,
  output logic [15:0]       stat_hit,
  output logic [15:0]       stat_miss,
  output logic [15:0]       stat_wb
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVAL,
    ST_WB,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        nxt_st_q;
  logic [1:0]        rsp_q;
  logic              present_q;

  logic              lk_present;
  snp_dec_t          dec_w;

  assign lk_present = line_present(lk_hit, lk_st);

  snp_rsp_decode u_decode (
    .req     (req_q),
    .present (lk_present),
    .cur_st  (lk_st),
    .dec     (dec_w)
  );

  // State register; reset is synchronous and abandons any transaction in flight
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the snoop in IDLE and the lookup result plus its decode in EVAL
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= SNP_NO_REQ;
      addr_q    <= '0;
      data_q    <= '0;
      nxt_st_q  <= MESI_I;
      rsp_q     <= SNP_NO_RSP;
      present_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && snp_req != SNP_NO_REQ) begin
        req_q  <= snp_req;
        addr_q <= snp_addr;
      end
      if (state_q == ST_EVAL) begin
        data_q    <= lk_data;
        nxt_st_q  <= dec_w.nxt_st;
        rsp_q     <= dec_w.rsp;
        present_q <= lk_present;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (snp_req != SNP_NO_REQ) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_EVAL;
      ST_EVAL:   state_d = (lk_present && dec_w.wb) ? ST_WB : ST_RESP;
      ST_WB:     if (wb_ready) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state; address/data come from
  // capture registers, so they stay stable for the whole writeback wait
  always_comb begin
    snp_busy   = (state_q != ST_IDLE);
    lk_req     = (state_q == ST_LOOKUP);
    lk_addr    = addr_q;
    wb_valid   = (state_q == ST_WB);
    wb_addr    = addr_q;
    wb_data    = data_q;
    st_wr_en   = (state_q == ST_RESP) && present_q;
    st_wr_addr = addr_q;
    st_wr_val  = nxt_st_q;
    snp_rsp    = (state_q == ST_RESP) ? rsp_q : SNP_NO_RSP;
  end

`ifdef SNP_RSP_STAT_EN
  // Saturating statistics: hits/misses counted in RESP, writebacks on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hit  <= '0;
      stat_miss <= '0;
      stat_wb   <= '0;
    end else begin
      if (state_q == ST_RESP && present_q)  stat_hit  <= sat_inc16(stat_hit);
      if (state_q == ST_RESP && !present_q) stat_miss <= sat_inc16(stat_miss);
      if (state_q == ST_WB && wb_ready)     stat_wb   <= sat_inc16(stat_wb);
    end
  end
`endif

endmodule

// File: tb/tb_snp_rsp_ctrl.sv
// Self-checking bench for snp_rsp_ctrl. Inputs are driven and outputs sampled
// on the falling clock edge; a value driven at a falling edge is the one the
// DUT samples at the following rising edge.
module tb_snp_rsp_ctrl;
  import snp_rsp_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    snp_req;
  logic [AW-1:0] snp_addr;
  logic [1:0]    snp_rsp;
  logic          snp_busy;
  logic          lk_req;
  logic [AW-1:0] lk_addr;
  logic          lk_hit;
  logic [2:0]    lk_st;
  logic [DW-1:0] lk_data;
  logic          st_wr_en;
  logic [AW-1:0] st_wr_addr;
  logic [2:0]    st_wr_val;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
`ifdef SNP_RSP_STAT_EN
  logic [15:0]   stat_hit, stat_miss, stat_wb;
`endif

  always #5 clk = ~clk;

  snp_rsp_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .snp_req    (snp_req),
    .snp_addr   (snp_addr),
    .snp_rsp    (snp_rsp),
    .snp_busy   (snp_busy),
    .lk_req     (lk_req),
    .lk_addr    (lk_addr),
    .lk_hit     (lk_hit),
    .lk_st      (lk_st),
    .lk_data    (lk_data),
    .st_wr_en   (st_wr_en),
    .st_wr_addr (st_wr_addr),
    .st_wr_val  (st_wr_val),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready)
`ifdef SNP_RSP_STAT_EN
    ,
    .stat_hit   (stat_hit),
    .stat_miss  (stat_miss),
    .stat_wb    (stat_wb)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_hit    = 0;
  int m_miss   = 0;
  int m_wb     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lookup bus carries junk outside its valid cycle
  task automatic garbage_lk();
    lk_hit  = 1'($urandom);
    lk_st   = 3'($urandom_range(0, 3));
    lk_data = $urandom;
  endtask

  // One full snoop, cycle-exact from the IDLE cycle in which it is presented.
  // Expected behaviour comes from the protocol table: present = hit and not
  // INVALID; present -> FOUND, RD leaves SHARED, others INVALID, MODIFIED
  // writes back; absent -> FETCH with no side effects.
  task automatic run_txn(input logic [2:0] req, input logic [AW-1:0] addr,
                         input logic hit, input logic [2:0] st,
                         input logic [DW-1:0] data, input int stall);
    logic       present, wb;
    logic [1:0] exp_rsp;
    logic [2:0] exp_st;
    present = hit && (st != MESI_I);
    wb      = present && (st == MESI_M);
    exp_rsp = present ? SNP_FOUND : SNP_FETCH;
    exp_st  = (req == SNP_RD) ? MESI_S : MESI_I;

    // cycle 0: IDLE, request presented
    check("idle_busy", snp_busy, 1'b0);
    snp_req  = req;
    snp_addr = addr;
    wb_ready = 1'($urandom);
    garbage_lk();
    @(negedge clk);
    // cycle 1: LOOKUP
    check("lk_req_c1", lk_req, 1'b1);
    check("lk_addr_c1", lk_addr, addr);
    check("busy_c1", snp_busy, 1'b1);
    check("rsp_c1", snp_rsp, SNP_NO_RSP);
    snp_addr = $urandom;
    garbage_lk();
    @(negedge clk);
    // cycle 2: EVAL, lookup result valid now
    check("lk_req_c2", lk_req, 1'b0);
    check("rsp_c2", snp_rsp, SNP_NO_RSP);
    check("wbv_c2", wb_valid, 1'b0);
    lk_hit  = hit;
    lk_st   = st;
    lk_data = data;
    @(negedge clk);
    garbage_lk();
    if (wb) begin
      for (int k = 0; k <= stall; k++) begin
        check("wb_valid", wb_valid, 1'b1);
        check("wb_addr", wb_addr, addr);
        check("wb_data", wb_data, data);
        check("wb_rsp", snp_rsp, SNP_NO_RSP);
        check("wb_stwr", st_wr_en, 1'b0);
        wb_ready = (k == stall);
        @(negedge clk);
      end
      m_wb++;
      wb_ready = 1'($urandom);
    end
    // RESP cycle
    check("rsp", snp_rsp, exp_rsp);
    check("rsp_wbv", wb_valid, 1'b0);
    check("rsp_busy", snp_busy, 1'b1);
    check("st_wr_en", st_wr_en, present);
    if (present) begin
      check("st_wr_addr", st_wr_addr, addr);
      check("st_wr_val", st_wr_val, exp_st);
      m_hit++;
    end else begin
      m_miss++;
    end
    snp_req  = SNP_NO_REQ;
    snp_addr = $urandom;
    @(negedge clk);
    // back in IDLE
    check("post_rsp", snp_rsp, SNP_NO_RSP);
    check("post_stwr", st_wr_en, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    snp_req  = SNP_NO_REQ;
    snp_addr = '0;
    wb_ready = 1'b0;
    garbage_lk();
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_rsp", snp_rsp, SNP_NO_RSP);
    check("rst_busy", snp_busy, 1'b0);
    check("rst_lk_req", lk_req, 1'b0);
    check("rst_stwr", st_wr_en, 1'b0);
    check("rst_wbv", wb_valid, 1'b0);
    check("rst_wb_addr", wb_addr, '0);
    check("rst_wb_data", wb_data, '0);
    check("rst_lk_addr", lk_addr, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn(SNP_RD,    32'h100, 1'b1, MESI_E, 32'h1234_5678, 0);
    run_txn(SNP_RD,    32'h100, 1'b1, MESI_M, 32'hDEAD_BEEF, 2);
    run_txn(SNP_RWITM, 32'h200, 1'b0, MESI_M, 32'h0BAD_F00D, 0);
    run_txn(SNP_INV,   32'h300, 1'b1, MESI_S, 32'h5555_AAAA, 0);
    run_txn(SNP_INV,   32'h300, 1'b1, MESI_I, 32'h0000_0001, 0);
    run_txn(SNP_RWITM, 32'h240, 1'b1, MESI_M, 32'hCAFE_0001, 0);

    // Reset while a writeback is stalled
    snp_req  = SNP_RD;
    snp_addr = 32'h400;
    wb_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lk_hit  = 1'b1;
    lk_st   = MESI_M;
    lk_data = 32'hFEED_FACE;
    @(negedge clk);
    check("rstwb_pre_wbv", wb_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstwb_wbv", wb_valid, 1'b0);
    check("rstwb_busy", snp_busy, 1'b0);
    check("rstwb_rsp", snp_rsp, SNP_NO_RSP);
    check("rstwb_stwr", st_wr_en, 1'b0);
    check("rstwb_wb_addr", wb_addr, '0);
    snp_req = SNP_NO_REQ;
    rst_n   = 1'b1;
    m_hit   = 0;
    m_miss  = 0;
    m_wb    = 0;
    @(negedge clk);
    check("rstwb_idle", snp_busy, 1'b0);
    run_txn(SNP_RD, 32'h100, 1'b1, MESI_S, 32'h7777_0000, 0);

    // Randomized snoops
    for (int i = 0; i < 60; i++) begin
      run_txn(3'($urandom_range(1, 3)), $urandom, 1'($urandom),
              3'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3));
    end

`ifdef SNP_RSP_STAT_EN
    check("stat_hit", stat_hit, 16'(m_hit));
    check("stat_miss", stat_miss, 16'(m_miss));
    check("stat_wb", stat_wb, 16'(m_wb));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
